// File: rtl/m72_irq_sequencer.sv
// m72_irq_sequencer: raster-line load port, VBLK/HINT edge capture, prioritised
// maskable interrupt request and an 8259-style acknowledge/vector handshake.
module m72_irq_sequencer (
  input  logic        CLK_32M,
  input  logic        RESET,
  input  logic        CE_PIX,
  input  logic        VBLK,
  input  logic        HINT,
  input  logic        CPU_WR,
  input  logic [1:0]  CPU_ADDR,
  input  logic [15:0] CPU_DIN,
  input  logic        INTA,
  output logic [15:0] TG_D,
  output logic        TG_ISET,
  output logic        IRQ,
  output logic [7:0]  VECTOR,
  output logic        VEC_VALID,
  output logic [7:0]  STATUS
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StLatch   = 2'd1;
  localparam logic [1:0] StDrive   = 2'd2;
  localparam logic [1:0] StRelease = 2'd3;

  logic [8:0] r_line;
  logic [1:0] r_en;
  logic [4:0] r_base;
  logic [1:0] r_pend;
  logic [1:0] r_isr;
  logic [1:0] r_state;
  logic       r_vblk_q;
  logic       r_hint_q;
  logic       r_inta_q;
  logic       r_irq;
  logic [7:0] r_vector;
  logic       r_tg_iset;
  logic       r_first;

  logic       w_wr_line;
  logic       w_wr_en;
  logic       w_wr_base;
  logic       w_wr_eoi;
  logic [1:0] w_ev;
  logic [1:0] w_elig;
  logic       w_found;
  logic       w_sel;
  logic       w_latch;
  logic       w_inta_rise;
  logic [1:0] w_pend_d;
  logic [1:0] w_isr_d;
  logic [1:0] w_state_d;
  logic       w_unused;

  // Only the low nine data bits ever reach a register.
  assign w_unused = ^CPU_DIN[15:9];

  assign w_wr_line = CPU_WR && (CPU_ADDR == 2'd0);
  assign w_wr_en   = CPU_WR && (CPU_ADDR == 2'd1);
  assign w_wr_base = CPU_WR && (CPU_ADDR == 2'd2);
  assign w_wr_eoi  = CPU_WR && (CPU_ADDR == 2'd3);

  assign w_ev[0] = CE_PIX & VBLK & ~r_vblk_q;
  assign w_ev[1] = CE_PIX & HINT & ~r_hint_q;

  // A set isr bit blocks its own source and every lower-priority one.
  assign w_elig[0] = r_pend[0] & ~r_isr[0];
  assign w_elig[1] = r_pend[1] & ~(|r_isr);
  assign w_found   = |w_elig;
  assign w_sel     = ~w_elig[0];

  assign w_latch     = (r_state == StLatch);
  assign w_inta_rise = INTA & ~r_inta_q;

  // Next pending/in-service: latch clear, then event set, then disable mask.
  always_comb begin
    w_pend_d = r_pend;
    if (w_latch && w_found) begin
      w_pend_d[w_sel] = 1'b0;
    end
    w_pend_d = w_pend_d | (w_ev & r_en);
    if (w_wr_en) begin
      w_pend_d = w_pend_d & CPU_DIN[1:0];
    end

    w_isr_d = r_isr;
    if (w_wr_eoi) begin
      w_isr_d = w_isr_d & ~CPU_DIN[1:0];
    end
    if (w_latch && w_found) begin
      w_isr_d[w_sel] = 1'b1;
    end
  end

  // Acknowledge handshake next-state.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (w_inta_rise) w_state_d = StLatch;
      StLatch:   w_state_d = StDrive;
      StDrive:   if (!INTA) w_state_d = StRelease;
      default:   w_state_d = StIdle;
    endcase
  end

  // All state, with synchronous reset.
  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      r_line    <= 9'd0;
      r_en      <= 2'b00;
      r_base    <= 5'd0;
      r_pend    <= 2'b00;
      r_isr     <= 2'b00;
      r_state   <= StIdle;
      r_vblk_q  <= 1'b1;
      r_hint_q  <= 1'b1;
      r_inta_q  <= 1'b1;
      r_irq     <= 1'b0;
      r_vector  <= 8'd0;
      r_tg_iset <= 1'b0;
      r_first   <= 1'b1;
    end else begin
      if (w_wr_line) r_line <= CPU_DIN[8:0];
      if (w_wr_en)   r_en   <= CPU_DIN[1:0];
      if (w_wr_base) r_base <= CPU_DIN[7:3];
      r_pend    <= w_pend_d;
      r_isr     <= w_isr_d;
      r_state   <= w_state_d;
      if (CE_PIX) begin
        r_vblk_q <= VBLK;
        r_hint_q <= HINT;
      end
      r_inta_q  <= INTA;
      r_irq     <= w_found;
      if (w_latch) begin
        r_vector <= w_found ? {r_base, w_sel, 2'b00} : {r_base, 3'b111};
      end
      // The first post-reset strobe loads line 0 into the generator.
      r_tg_iset <= w_wr_line | r_first;
      r_first   <= 1'b0;
    end
  end

  assign TG_D      = {7'b0, r_line};
  assign TG_ISET   = r_tg_iset;
  assign IRQ       = r_irq;
  assign VECTOR    = r_vector;
  assign VEC_VALID = (r_state == StDrive);
  assign STATUS    = {2'b00, r_state, r_isr, r_pend};

endmodule

// File: tb/tb_m72_irq_sequencer.sv
// Self-checking bench for m72_irq_sequencer: directed scenarios plus random
// traffic, every cycle compared against a behavioural model.
module tb_m72_irq_sequencer;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        CE_PIX = 1'b1;
  logic        VBLK = 1'b0;
  logic        hint_in = 1'b0;
  logic        CPU_WR = 1'b0;
  logic [1:0]  CPU_ADDR = 2'd0;
  logic [15:0] CPU_DIN = 16'd0;
  logic        INTA = 1'b0;
  logic [15:0] TG_D;
  logic        TG_ISET;
  logic        IRQ;
  logic [7:0]  VECTOR;
  logic        VEC_VALID;
  logic [7:0]  STATUS;

  int n_checks = 0;
  int n_err = 0;

  // Model state (plain integers, phase 0..3 = idle/latch/drive/release).
  int m_line, m_base, m_st, m_irq, m_vec, m_iset, m_tgd, m_first, m_inta_last;
  int m_en[2];
  int m_pend[2];
  int m_isr[2];
  int m_last[2];

  m72_irq_sequencer dut (
    .CLK_32M  (clk),
    .RESET    (RESET),
    .CE_PIX   (CE_PIX),
    .VBLK     (VBLK),
    .HINT     (hint_in),
    .CPU_WR   (CPU_WR),
    .CPU_ADDR (CPU_ADDR),
    .CPU_DIN  (CPU_DIN),
    .INTA     (INTA),
    .TG_D     (TG_D),
    .TG_ISET  (TG_ISET),
    .IRQ      (IRQ),
    .VECTOR   (VECTOR),
    .VEC_VALID(VEC_VALID),
    .STATUS   (STATUS)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT samples.
  task automatic model_step();
    int in_v[2];
    int elig[2];
    int np[2];
    int ni[2];
    int ev[2];
    int sel;
    int rise;
    int nst;
    if (RESET) begin
      m_line = 0; m_base = 0; m_st = 0; m_irq = 0; m_vec = 0; m_iset = 0; m_tgd = 0;
      m_first = 1; m_inta_last = 1;
      for (int s = 0; s < 2; s++) begin
        m_en[s] = 0; m_pend[s] = 0; m_isr[s] = 0; m_last[s] = 1;
      end
      return;
    end
    in_v[0] = int'(VBLK);
    in_v[1] = int'(hint_in);
    for (int s = 0; s < 2; s++) begin
      elig[s] = m_pend[s];
      for (int k = 0; k <= s; k++) if (m_isr[k] != 0) elig[s] = 0;
      ev[s] = (CE_PIX && in_v[s] != 0 && m_last[s] == 0) ? 1 : 0;
      np[s] = m_pend[s];
      ni[s] = m_isr[s];
    end
    rise = (INTA && m_inta_last == 0) ? 1 : 0;
    // EOI
    if (CPU_WR && CPU_ADDR == 2'd3)
      for (int s = 0; s < 2; s++) if (CPU_DIN[s]) ni[s] = 0;
    // acknowledge
    nst = m_st;
    case (m_st)
      0: if (rise != 0) nst = 1;
      1: begin
        sel = -1;
        for (int s = 1; s >= 0; s--) if (elig[s] != 0) sel = s;
        if (sel >= 0) begin
          m_vec = m_base * 8 + sel * 4;
          np[sel] = 0;
          ni[sel] = 1;
        end else begin
          m_vec = m_base * 8 + 7;
        end
        nst = 2;
      end
      2: if (!INTA) nst = 3;
      default: nst = 0;
    endcase
    // events use the enables in force before this edge
    for (int s = 0; s < 2; s++) if (ev[s] != 0 && m_en[s] != 0) np[s] = 1;
    if (CPU_WR && CPU_ADDR == 2'd1)
      for (int s = 0; s < 2; s++) begin
        m_en[s] = int'(CPU_DIN[s]);
        if (!CPU_DIN[s]) np[s] = 0;
      end
    if (CPU_WR && CPU_ADDR == 2'd2) m_base = int'(CPU_DIN[7:3]);
    if (CPU_WR && CPU_ADDR == 2'd0) begin
      m_line = int'(CPU_DIN[8:0]);
      m_tgd = m_line;
      m_iset = 1;
    end else if (m_first != 0) begin
      m_tgd = 0;
      m_iset = 1;
    end else begin
      m_iset = 0;
    end
    m_first = 0;
    m_irq = (elig[0] != 0 || elig[1] != 0) ? 1 : 0;
    for (int s = 0; s < 2; s++) begin
      m_pend[s] = np[s];
      m_isr[s] = ni[s];
      if (CE_PIX) m_last[s] = in_v[s];
    end
    m_inta_last = int'(INTA);
    m_st = nst;
  endtask

  task automatic compare_all();
    int st_v;
    st_v = m_st * 16 + m_isr[1] * 8 + m_isr[0] * 4 + m_pend[1] * 2 + m_pend[0];
    check_eq("irq", 32'(IRQ), 32'(m_irq));
    check_eq("vec_valid", 32'(VEC_VALID), (m_st == 2) ? 32'd1 : 32'd0);
    check_eq("vector", 32'(VECTOR), 32'(m_vec));
    check_eq("tg_iset", 32'(TG_ISET), 32'(m_iset));
    check_eq("tg_d", 32'(TG_D), 32'(m_tgd));
    check_eq("status", 32'(STATUS), 32'(st_v));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    CPU_WR = 1'b1; CPU_ADDR = a; CPU_DIN = d;
    tick();
    CPU_WR = 1'b0;
  endtask

  task automatic ack(input string tag, input logic [7:0] exp_vec);
    INTA = 1'b1;
    tick();
    tick();
    check_eq({tag, "_valid"}, 32'(VEC_VALID), 32'd1);
    check_eq({tag, "_vector"}, 32'(VECTOR), 32'(exp_vec));
    tick();
    INTA = 1'b0;
    tick();
    tick();
    check_eq({tag, "_released"}, 32'(VEC_VALID), 32'd0);
  endtask

  initial begin
    // reset and post-reset strobe
    RESET = 1'b1;
    repeat (3) tick();
    check_eq("rst_irq", 32'(IRQ), 32'd0);
    check_eq("rst_iset", 32'(TG_ISET), 32'd0);
    RESET = 1'b0;
    tick();
    check_eq("post_rst_iset", 32'(TG_ISET), 32'd1);
    check_eq("post_rst_tgd", 32'(TG_D), 32'h0000);
    check_eq("post_rst_vvalid", 32'(VEC_VALID), 32'd0);
    tick();
    check_eq("post_rst_iset_end", 32'(TG_ISET), 32'd0);

    // raster load, back-to-back
    wr(2'd0, 16'h0123);
    check_eq("load_iset", 32'(TG_ISET), 32'd1);
    check_eq("load_tgd", 32'(TG_D), 32'h0123);
    wr(2'd0, 16'h00aa);
    check_eq("load2_tgd", 32'(TG_D), 32'h00aa);
    tick();
    check_eq("load_iset_end", 32'(TG_ISET), 32'd0);

    // vblank interrupt
    wr(2'd1, 16'h0003);
    wr(2'd2, 16'h0020);
    VBLK = 1'b1;
    tick();
    check_eq("vblk_irq_early", 32'(IRQ), 32'd0);
    tick();
    check_eq("vblk_irq", 32'(IRQ), 32'd1);
    ack("ack_vblk", 8'h20);
    check_eq("vblk_isr", 32'(STATUS[3:2]), 32'd1);
    check_eq("vblk_irq_clr", 32'(IRQ), 32'd0);
    VBLK = 1'b0;
    tick();

    // raster blocked by in-service vblank, then released by EOI
    hint_in = 1'b1;
    repeat (3) tick();
    check_eq("nest_blocked", 32'(IRQ), 32'd0);
    wr(2'd3, 16'h0001);
    tick();
    check_eq("nest_irq", 32'(IRQ), 32'd1);
    ack("ack_raster", 8'h24);
    wr(2'd3, 16'h0002);
    hint_in = 1'b0;
    tick();

    // masked source and spurious acknowledge
    wr(2'd1, 16'h0000);
    hint_in = 1'b1; tick(); hint_in = 1'b0; tick(); hint_in = 1'b1; tick();
    check_eq("mask_pend", 32'(STATUS[1:0]), 32'd0);
    ack("ack_spur", 8'h27);
    check_eq("spur_isr", 32'(STATUS[3:2]), 32'd0);
    hint_in = 1'b0;
    tick();

    // event coinciding with the latch cycle of the same source
    wr(2'd1, 16'h0003);
    VBLK = 1'b1; tick();
    VBLK = 1'b0; tick();
    tick();
    INTA = 1'b1;
    tick();
    VBLK = 1'b1;
    tick();
    check_eq("sim_pend", 32'(STATUS[0]), 32'd1);
    check_eq("sim_isr", 32'(STATUS[2]), 32'd1);
    INTA = 1'b0;
    tick(); tick();
    VBLK = 1'b0;
    tick();
    check_eq("sim_irq_blocked", 32'(IRQ), 32'd0);
    wr(2'd3, 16'h0001);
    tick();
    check_eq("sim_irq_reassert", 32'(IRQ), 32'd1);
    ack("ack_again", 8'h20);
    wr(2'd3, 16'h0001);

    // disable written in the same cycle as an event
    tick();
    VBLK = 1'b1;
    wr(2'd1, 16'h0000);
    check_eq("dis_pend", 32'(STATUS[1:0]), 32'd0);
    VBLK = 1'b0;
    tick();

    // reset in the middle of a handshake
    wr(2'd1, 16'h0003);
    INTA = 1'b1;
    tick(); tick();
    RESET = 1'b1;
    tick();
    check_eq("midrst_status", 32'(STATUS), 32'd0);
    check_eq("midrst_vvalid", 32'(VEC_VALID), 32'd0);
    RESET = 1'b0;
    INTA = 1'b0;
    tick();
    check_eq("midrst_iset", 32'(TG_ISET), 32'd1);
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      RESET = ($urandom_range(0, 399) == 0);
      CE_PIX = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) VBLK = ~VBLK;
      if ($urandom_range(0, 7) == 0) hint_in = ~hint_in;
      if ($urandom_range(0, 3) == 0) INTA = ~INTA;
      CPU_WR = ($urandom_range(0, 5) == 0);
      CPU_ADDR = 2'($urandom_range(0, 3));
      CPU_DIN = 16'($urandom);
      tick();
    end
    RESET = 1'b0;
    CPU_WR = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/m72_irq_sequencer.md
# m72_irq_sequencer

Interrupt and raster-configuration controller sitting between the V30 CPU bus and the video timing generator. It owns the raster-interrupt line register and pushes it into the timing generator via its `D`/`ISET` load port. It turns the generator's `VBLK` and `HINT` outputs into prioritised, maskable CPU interrupts, and runs an 8259-style acknowledge/vector handshake with in-service tracking and EOI.

## Interface
- No parameters.
- `CLK_32M`  in  1  system clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `CE_PIX`  in  1  pixel clock enable; timing inputs are sampled only when high.
- `VBLK`  in  1  vertical blank from the timing generator.
- `HINT`  in  1  raster-match flag from the timing generator; level-high for the whole matching line.
- `CPU_WR`  in  1  single-cycle register write strobe.
- `CPU_ADDR`  in  2  register select.
- `CPU_DIN`  in  16  write data.
- `INTA`  in  1  CPU interrupt-acknowledge level.
- `TG_D`  out  16  load data to the timing generator `D`.
- `TG_ISET`  out  1  load strobe to the timing generator `ISET`.
- `IRQ`  out  1  interrupt request to the CPU.
- `VECTOR`  out  8  interrupt vector.
- `VEC_VALID`  out  1  `VECTOR` is valid.
- `STATUS`  out  8  `{2'b0, state[1:0], isr[1:0], pend[1:0]}`.

## Operation
- Sources: bit0 = vblank (highest priority), bit1 = raster.
- Registers written on `CPU_WR`:
  - addr0: `line <= CPU_DIN[8:0]`.
  - addr1: `en <= CPU_DIN[1:0]`. Also `pend <= pend & CPU_DIN[1:0]`, so disabling a source clears its pending bit.
  - addr2: `base <= CPU_DIN[7:3]`.
  - addr3 (EOI): `isr <= isr & ~CPU_DIN[1:0]`.
- Raster load:
  - The cycle after an addr0 write: `TG_ISET=1`, `TG_D={7'b0, line_new}`, for exactly 1 cycle.
  - The first cycle after `RESET` deasserts: one `TG_ISET` with `TG_D=0`.
- Edge detect: `vblk_q` and `hint_q` update only when `CE_PIX=1`. An event fires on a `CE_PIX` cycle where the input is 1 and its `_q` is 0.
  - Event on source s with `en[s]=1`: `pend[s] <= 1`.
  - Event with `en[s]=0`: ignored.
- Eligibility: source s is eligible if `pend[s]=1` and no `isr` bit of equal or higher priority is set.
- `IRQ` = registered OR of eligible sources; it updates one cycle after `pend`/`isr` change.
- Acknowledge FSM (`state` encoding: IDLE=0, LATCH=1, DRIVE=2, RELEASE=3):
  - IDLE: `INTA` rising edge (vs. `inta_q`) -> LATCH.
  - LATCH (1 cycle): select the highest-priority eligible source s.
    - If found: `VECTOR={base, s, 2'b00}` (vblank -> base+0, raster -> base+4), `pend[s] <= 0`, `isr[s] <= 1`.
    - If none: `VECTOR={base, 3'b111}` (spurious); `pend`/`isr` unchanged.
    - Then -> DRIVE.
  - DRIVE: `VEC_VALID=1`. Stay while `INTA=1`. When `INTA=0` -> RELEASE.
  - RELEASE (1 cycle): `VEC_VALID=0` -> IDLE.
- Simultaneous events:
  - Event and LATCH-clear on the same source in one cycle: set wins, `pend` stays 1.
  - Event and addr1 write disabling that source in one cycle: clear wins.
  - EOI and LATCH setting the same `isr` bit in one cycle: set wins.
- `INTA` is ignored outside IDLE; a new acknowledge requires `INTA` to fall and rise again.

## Timing
- Reset values: `line=0`, `en=0`, `base=0`, `pend=0`, `isr=0`, `state=IDLE`, `vblk_q=1`, `hint_q=1` (no spurious edge at reset), `IRQ=0`, `VECTOR=0`, `VEC_VALID=0`, `TG_ISET=0`, `TG_D=0`.
- `RESET` asserted mid-handshake returns to IDLE and the reset values next cycle; the post-reset `TG_ISET` still fires.
- Write -> `TG_ISET` latency: 1 cycle. Back-to-back addr0 writes give back-to-back strobes, each carrying its own data.
- Event `CE_PIX` cycle -> `pend` set at the next edge -> `IRQ` high one cycle later (2 cycles total).
- `INTA` rise seen at edge n -> LATCH during cycle n+1 -> `VEC_VALID`/`VECTOR` valid from cycle n+2.
- `VECTOR` holds its value until the next LATCH.

## Test plan
- Reset: hold `RESET` 3 cycles, release -> exactly one `TG_ISET` pulse with `TG_D=0x0000` on the first cycle after release; `IRQ=0`, `VEC_VALID=0`.
- Raster load: write addr0 `0x0123` -> next cycle `TG_ISET=1`, `TG_D=0x0123`; the following cycle `TG_ISET=0`.
- Vblank IRQ: `en=3`, `base=0x20`; raise `VBLK` on a `CE_PIX` cycle -> `IRQ=1` 2 cycles later. Pulse `INTA` -> `VECTOR=0x20`, `VEC_VALID=1`, `isr=01`, `IRQ=0`.
- Priority/nesting: `isr=01` set, raster event -> `IRQ` stays 0. Write addr3 `0x0001` -> `IRQ=1`. Acknowledge -> `VECTOR=0x24`.
- Spurious/masking: `en=0`, toggle `HINT` -> `pend` stays 0. `INTA` pulse -> `VECTOR=0x27`.
- Simultaneous events:
  - Vblank event in the LATCH cycle acknowledging vblank -> `pend[0]` remains 1, `IRQ` reasserts after EOI.
  - Disable write in the same cycle as an event -> `pend` 0.
